onehot_decoder_seq: RTL
=======================

// Module: onehot_decoder_seq
// PURPOSE
//  Parametrised, registered binary-to-one-hot decoder with valid/ready handshakes on both sides.
//  Successor to the fixed 4->16 combinational decoder.
//  Adds a SWEEP mode: one request walks the one-hot bit from a start index up to the MSB,
//  one beat per output handshake.
//  Drives downstream select/enable fabrics, e.g. channel scanners and bank-enable sequencers.
// PARAMETERS
//  BIN_W   4            binary input width
//  OUT_W   1<<BIN_W     one-hot output width (derived localparam; not overridable)
// PORTS
//  clk         in   1      single clock, rising edge
//  reset_n     in   1      asynchronous assert, active-low reset
//  in_valid    in   1      request valid
//  in_ready    out  1      request accepted when in_valid&&in_ready
//  in_bin      in   BIN_W  bit index (decode) / start index (sweep)
//  in_mode     in   1      0=DECODE, 1=SWEEP; sampled on accept
//  out_valid   out  1      output beat valid
//  out_ready   in   1      downstream accepts beat when out_valid&&out_ready
//  out_onehot  out  OUT_W  one-hot word, bit out_onehot[idx]=1
//  out_last    out  1      final beat of current request
//  busy        out  1      sweep in progress (state==SWEEP)
//  chk_err     out  1      only with ONEHOT_CHK_EN: sticky one-hot violation flag
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, out_valid=0, out_onehot=0, out_last=0, busy=0, idx=0, chk_err=0.
//  Reset mid-sweep aborts the sweep; no further beats are emitted.
//  FSM states: IDLE, SWEEP.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; 1 out of reset.
//  Output stage: out_* registered; held stable while out_valid && !out_ready (no drop, no change).
//  DECODE accept:
//   - next cycle out_valid=1, out_onehot=1<<in_bin, out_last=1.
//   - State stays IDLE. Latency 1 cycle.
//   - Back-to-back accepts give 1 beat/cycle while out_ready=1.
//  SWEEP accept:
//   - idx<=in_bin; next cycle out_valid=1, out_onehot=1<<in_bin, out_last=(in_bin==OUT_W-1).
//   - If in_bin==OUT_W-1: single beat, stay IDLE; otherwise go to SWEEP.
//  SWEEP state, on each output handshake:
//   - idx<=idx+1; beat 1<<(idx+1); out_last=(idx+1==OUT_W-1).
//   - Beats are presented back-to-back with no bubble while out_ready=1.
//   - The handshake of the beat with out_last=1 moves state to IDLE. idx never wraps.
//  in_ready=0 throughout SWEEP. New requests are stalled, not dropped.
//  Handshake in the same cycle as the final handshake:
//   - A beat handshaken while in IDLE (decode, or single-beat sweep) frees the stage,
//     so in_ready=1 and a new request is accepted in the same cycle.
//   - The final handshake of a multi-beat sweep sees state==SWEEP, so in_ready=0;
//     the next request is accepted one cycle later.
//  Out of range: none possible (OUT_W=2^BIN_W); all in_bin values legal.
//  Outputs never contain X after reset; out_onehot=0 whenever out_valid=0 after the last beat drains.
// CONFIGURATION
//  Macro ONEHOT_CHK_EN:
//   - Defined: port chk_err exists.
//     Sets to 1 the cycle after out_valid=1 with $countones(out_onehot)!=1,
//     or with out_onehot changing while stalled. Sticky until reset.
//   - Undefined: port and logic absent.
// STRUCTURE
//  Package onehot_pkg:
//   - typedef enum logic {DECODE=1'b0, SWEEP=1'b1} mode_e;
//   - typedef enum logic {ST_IDLE, ST_SWEEP} state_e;
//   - localparam int BIN_W_DEFAULT=4.
//  Sub-module bin2onehot #(BIN_W): purely combinational idx->one-hot.
//   Instantiated once, fed by the mux of in_bin (accept) / idx+1 (advance).
// TESTING
//  1 Reset: hold reset_n=0 3 cycles -> out_valid=0, out_onehot=16'h0000, busy=0, in_ready=1.
//  2 Decode, BIN_W=4, out_ready=1, in_bin=5 -> next cycle out_onehot=16'h0020, out_last=1.
//    Then in_bin=0,15 back-to-back -> 16'h0001, 16'h8000 on consecutive cycles.
//  3 Sweep in_bin=12, out_ready=1 -> beats 16'h1000,16'h2000,16'h4000,16'h8000.
//    out_last only on 16'h8000; busy=1 until the final beat; in_ready=0 during the sweep.
//  4 Backpressure: sweep in_bin=13, out_ready=0 for 4 cycles -> 16'h2000 held stable;
//    release -> 16'h4000, 16'h8000, no beat lost or repeated.
//  5 Reset mid-sweep: sweep in_bin=0, assert reset_n=0 after 3 beats ->
//    out_valid=0 immediately; after release no residual beats; in_ready=1.
//  6 BIN_W=3 sweep in_bin=7 -> single beat 8'h80 with out_last=1, busy stays 0.
//    With ONEHOT_CHK_EN, a full-range random run -> chk_err stays 0.

Source files
------------

// File: rtl/onehot_decoder_seq_pkg.sv
// Shared types and defaults for the registered one-hot decoder/sweeper.
// Package onehot_pkg is imported by onehot_decoder_seq and bin2onehot.
package onehot_pkg;

    typedef enum logic {DECODE = 1'b0, SWEEP = 1'b1} mode_e;

    typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

    localparam int BIN_W_DEFAULT = 4;

endpackage

// File: rtl/onehot_decoder_seq_bin2onehot.sv
// Purely combinational binary index to one-hot converter.
// Shared by the accept path and the sweep-advance path of onehot_decoder_seq.
module bin2onehot
    import onehot_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEFAULT,
    localparam int OUT_W = 1 << BIN_W
) (
    input  logic [BIN_W-1:0] bin,
    output logic [OUT_W-1:0] onehot
);

    assign onehot = OUT_W'(1) << bin;

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides and a SWEEP mode.
// Optional macro ONEHOT_CHK_EN adds the sticky one-hot/stability checker output chk_err.
module onehot_decoder_seq
    import onehot_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEFAULT,
    localparam int OUT_W = 1 << BIN_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_bin,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_last,
    output logic             busy
`ifdef ONEHOT_CHK_EN
    ,
    output logic             chk_err
`endif
);

    localparam logic [BIN_W-1:0] MAX_IDX = '1;

    state_e           state_q, state_d;
    logic [BIN_W-1:0] idx_q, idx_d;
    logic [BIN_W-1:0] idx_inc;
    logic [BIN_W-1:0] dec_sel;
    logic [OUT_W-1:0] dec_onehot;

    logic             vld_p1, vld_d;
    logic [OUT_W-1:0] onehot_p1, onehot_d;
    logic             last_p1, last_d;

    logic             fire_in;
    logic             fire_out;
    logic             is_sweep_req;

    // Stage 0: request acceptance and decoder operand selection
    assign in_ready     = (state_q == ST_IDLE) && (!vld_p1 || out_ready);
    assign fire_in      = in_valid && in_ready;
    assign fire_out     = vld_p1 && out_ready;
    assign is_sweep_req = (mode_e'(in_mode) == SWEEP);
    assign idx_inc      = idx_q + BIN_W'(1);
    assign dec_sel      = (state_q == ST_IDLE) ? in_bin : idx_inc;

    bin2onehot #(.BIN_W(BIN_W)) u_bin2onehot (
        .bin    (dec_sel),
        .onehot (dec_onehot)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vld_d    = vld_p1;
        onehot_d = onehot_p1;
        last_d   = last_p1;
        case (state_q)
            ST_IDLE: begin
                if (fire_in) begin
                    vld_d    = 1'b1;
                    onehot_d = dec_onehot;
                    if (is_sweep_req) begin
                        idx_d  = in_bin;
                        last_d = (in_bin == MAX_IDX);
                        if (in_bin != MAX_IDX) begin
                            state_d = ST_SWEEP;
                        end
                    end else begin
                        last_d = 1'b1;
                    end
                end else if (fire_out) begin
                    vld_d    = 1'b0;
                    onehot_d = '0;
                    last_d   = 1'b0;
                end
            end
            ST_SWEEP: begin
                // The final beat never advances idx, so it cannot wrap past MAX_IDX.
                if (fire_out) begin
                    if (last_p1) begin
                        state_d  = ST_IDLE;
                        vld_d    = 1'b0;
                        onehot_d = '0;
                        last_d   = 1'b0;
                    end else begin
                        idx_d    = idx_inc;
                        onehot_d = dec_onehot;
                        last_d   = (idx_inc == MAX_IDX);
                    end
                end
            end
        endcase
    end

    // Stage 1: registered output beat and sweep state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            vld_p1    <= 1'b0;
            onehot_p1 <= '0;
            last_p1   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vld_p1    <= vld_d;
            onehot_p1 <= onehot_d;
            last_p1   <= last_d;
        end
    end

    assign out_valid  = vld_p1;
    assign out_onehot = onehot_p1;
    assign out_last   = last_p1;
    assign busy       = (state_q == ST_SWEEP);

`ifdef ONEHOT_CHK_EN
    logic             stall_p2;
    logic [OUT_W-1:0] held_p2;
    logic             chk_err_q;

    function automatic logic is_onehot(input logic [OUT_W-1:0] w);
        return (w != '0) && ((w & (w - OUT_W'(1))) == '0);
    endfunction

    // Stage 2: observe the presented beat one cycle later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_p2  <= 1'b0;
            held_p2   <= '0;
            chk_err_q <= 1'b0;
        end else begin
            stall_p2 <= vld_p1 && !out_ready;
            held_p2  <= onehot_p1;
            if ((vld_p1 && !is_onehot(onehot_p1)) || (stall_p2 && (onehot_p1 != held_p2))) begin
                chk_err_q <= 1'b1;
            end
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule
